rx_pkt_byte_fifo: RTL

Packet-aware receive buffer between the `dot11` decoder's byte output and the host/DMA side. It stores decoded PSDU bytes speculatively, commits a packet when the FCS verdict arrives, and rolls back bad or overflowing packets. It replays committed packets as a valid/ready byte stream with per-packet length and FCS status.

---
 rtl/rx_pkt_byte_fifo.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rx_pkt_byte_fifo.sv
// rx_pkt_byte_fifo: packet-aware receive buffer; bytes are written speculatively,
// committed or rolled back on the FCS verdict, and replayed as a valid/ready stream.
module rx_pkt_byte_fifo #(
   parameter int ADDR_W   = 11,
   parameter int DESC_W   = 3,
   parameter bit DROP_BAD = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pkt_header_valid_strobe,
   input  logic [15:0] pkt_len,
   input  logic [7:0]  byte_out,
   input  logic        byte_out_strobe,
   input  logic        fcs_out_strobe,
   input  logic        fcs_ok,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic [15:0] m_pkt_len,
   output logic        m_fcs_ok,
   output logic [15:0] pkt_ok_count,
   output logic [15:0] pkt_drop_count,
   output logic        overflow
);
   localparam logic W_IDLE = 1'b0;
   localparam logic W_RECV = 1'b1;
   localparam logic R_IDLE = 1'b0;
   localparam logic R_SEND = 1'b1;
   localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [DESC_W:0] DDEPTH = {1'b1, {DESC_W{1'b0}}};

   logic [7:0]      r_mem  [2**ADDR_W];
   logic [16:0]     r_desc [2**DESC_W];
   logic            r_wstate, r_rstate, r_fcs_ok, r_overflow;
   logic [ADDR_W:0] r_wr_spec, r_wr_base, r_rd_ptr;
   logic [DESC_W:0] r_dwp, r_drp;
   logic [15:0]     r_wcnt, r_len, r_rcnt, r_pkt_len, r_ok_cnt, r_drop_cnt;
   logic [7:0]      r_data;

   logic            w_recv, w_full, w_byte_ok, w_wr, w_ovf, w_fcs, w_push, w_hdr_drop, w_drop;
   logic            w_dfull, w_dempty, w_pop, w_acc, w_last, w_rd_en;
   logic [15:0]     w_wcnt_n;
   logic [ADDR_W:0] w_spec_n, w_rd_addr;

   // A byte written in the same cycle as the FCS counts toward the packet; an
   // overflow drop ends the packet so a coincident FCS is ignored.
   assign w_recv     = r_wstate == W_RECV;
   assign w_full     = (r_wr_spec - r_rd_ptr) == DEPTH;
   assign w_byte_ok  = w_recv && byte_out_strobe && (r_wcnt < r_len);
   assign w_wr       = w_byte_ok && !w_full;
   assign w_ovf      = w_byte_ok && w_full;
   assign w_wcnt_n   = r_wcnt + 16'(w_wr);
   assign w_fcs      = w_recv && !w_ovf && fcs_out_strobe;
   assign w_dfull    = (r_dwp - r_drp) == DDEPTH;
   assign w_dempty   = r_dwp == r_drp;
   assign w_push     = w_fcs && (fcs_ok || !DROP_BAD) && !w_dfull && (w_wcnt_n != 16'd0);
   assign w_hdr_drop = w_recv && !w_ovf && !w_fcs && pkt_header_valid_strobe;
   assign w_drop     = w_ovf || (w_fcs && !w_push) || w_hdr_drop;
   assign w_spec_n   = w_drop ? r_wr_base : r_wr_spec + (ADDR_W+1)'(w_wr);

   assign w_pop     = (r_rstate == R_IDLE) && !w_dempty;
   assign w_acc     = (r_rstate == R_SEND) && m_ready;
   assign w_last    = (r_rstate == R_SEND) && (r_rcnt == r_pkt_len - 16'd1);
   assign w_rd_en   = w_pop || (w_acc && !w_last);
   assign w_rd_addr = w_pop ? r_rd_ptr : r_rd_ptr + (ADDR_W+1)'(1);

   assign m_data         = r_data;
   assign m_valid        = r_rstate == R_SEND;
   assign m_last         = w_last;
   assign m_pkt_len      = r_pkt_len;
   assign m_fcs_ok       = r_fcs_ok;
   assign pkt_ok_count   = r_ok_cnt;
   assign pkt_drop_count = r_drop_cnt;
   assign overflow       = r_overflow;

   always_ff @(posedge clock) begin
      if (w_wr) r_mem[r_wr_spec[ADDR_W-1:0]] <= byte_out;
      if (w_push) r_desc[r_dwp[DESC_W-1:0]] <= {w_wcnt_n, fcs_ok};
   end

   always_ff @(posedge clock) begin
      if (reset) r_data <= '0;
      else if (w_rd_en) r_data <= r_mem[w_rd_addr[ADDR_W-1:0]];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_wstate   <= W_IDLE;
         r_wr_spec  <= '0;
         r_wr_base  <= '0;
         r_wcnt     <= '0;
         r_len      <= '0;
         r_dwp      <= '0;
         r_ok_cnt   <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_wr_spec <= w_spec_n;
         if (pkt_header_valid_strobe) begin
            r_wstate  <= W_RECV;
            r_wr_base <= w_spec_n;
            r_wcnt    <= '0;
            r_len     <= pkt_len;
         end else begin
            r_wcnt <= w_wcnt_n;
            if (w_drop || w_fcs) r_wstate <= W_IDLE;
         end
         if (w_push) r_dwp <= r_dwp + (DESC_W+1)'(1);
         if (w_push && r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
         if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
         if (w_ovf) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rstate  <= R_IDLE;
         r_drp     <= '0;
         r_rd_ptr  <= '0;
         r_rcnt    <= '0;
         r_pkt_len <= '0;
         r_fcs_ok  <= 1'b0;
      end else if (w_pop) begin
         r_rstate              <= R_SEND;
         r_drp                 <= r_drp + (DESC_W+1)'(1);
         r_rcnt                <= '0;
         {r_pkt_len, r_fcs_ok} <= r_desc[r_drp[DESC_W-1:0]];
      end else if (w_acc) begin
         r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
         r_rcnt   <= r_rcnt + 16'd1;
         if (w_last) r_rstate <= R_IDLE;
      end
   end
endmodule
